mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-port unified instruction/data memory between the IF-stage fetch requester and the MEM-stage load/store requester.
- Sequences each memory transaction through a valid/ready handshake with the memory.
- Generates the stall signals the IF and MEM stages use to freeze the pipeline.
- Handles fetch redirect (flush) and memory timeout.

Parameters:
TIMEOUT_CYCLES, 255, busy cycles without mem_ready before abort (1..65535)
ERR_RDATA, 32'hDEADBEEF, read data returned on a timed-out transaction

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
if_req  in  1  fetch request; held until if_done
if_addr  in  32  fetch address
if_flush  in  1  discard in-flight fetch (branch/jump redirect)
if_rdata  out  32  fetched instruction, valid with if_done, held afterwards
if_done  out  1  one-cycle fetch completion pulse
if_stall  out  1  if_req & ~if_done
d_req  in  1  data request; held until d_done
d_we  in  1  1 = store, 0 = load
d_addr  in  32  data address
d_wdata  in  32  store data
d_be  in  4  store byte enables
d_rdata  out  32  load data, valid with d_done, held afterwards
d_done  out  1  one-cycle data completion pulse
d_stall  out  1  d_req & ~d_done
bus_err  out  1  one-cycle pulse coincident with a done pulse for a timed-out transaction
mem_req  out  1  memory request valid
mem_we  out  1  memory write strobe
mem_addr  out  32  memory address
mem_wdata  out  32  memory write data
mem_be  out  4  memory byte enables (4'hF on fetch)
mem_rdata  in  32  memory read data, valid when mem_ready
mem_ready  in  1  memory completes the current request this cycle

Behaviour:
- States: IDLE, IF_BUSY, D_BUSY.
- Reset (rst low, asynchronous): state IDLE; all outputs 0, including mem_req, the done pulses and bus_err; if_rdata and d_rdata = 0; timeout counter, drop flag and last_grant = 0.
- Reset mid-transaction: mem_req drops immediately; the transaction is lost and no done pulse is issued.
- IDLE arbitration, default:
  - d_req wins over if_req (older instruction first).
  - The winner's request fields are latched into the mem_* registers.
  - mem_req goes high the next cycle; state moves to D_BUSY or IF_BUSY.
  - IF_BUSY drives mem_we = 0 and mem_be = 4'hF.
- Memory handshake rules:
  - mem_req and all mem_* fields stay stable until a cycle in which mem_req & mem_ready.
  - On that edge: mem_req -> 0, rdata is captured, and the matching done pulses the following cycle.
  - The state then returns to IDLE.
  - Minimum latency: req sampled at edge N, mem_req high after N, mem_ready that cycle, done high after N+1.
  - IDLE is occupied for at least 1 cycle between transactions, so peak throughput is 1 transaction per 2 cycles.
- Stores: d_done pulses exactly as for loads; d_rdata is not updated.
- if_flush:
  - In IDLE, or with no fetch in flight: no effect.
  - During IF_BUSY: sets the drop flag. The memory transaction still completes (no cancellation), but if_done is suppressed and if_rdata is not updated.
  - The drop flag clears on return to IDLE.
  - if_flush in the same cycle as mem_ready still drops the response.
- Requester deasserts req while busy: the transaction completes and done still pulses; the requester ignores it.
- Timeout:
  - The counter clears on entry to a busy state and increments each busy cycle without mem_ready.
  - When it reaches TIMEOUT_CYCLES: mem_req -> 0; next cycle the matching done pulses with bus_err = 1.
  - Read data returned is ERR_RDATA; it is suppressed for a dropped fetch, though bus_err still pulses.
  - State returns to IDLE.
- Simultaneous events: mem_ready on the same edge the counter reaches the limit counts as success, with no bus_err.
- Only one of if_done and d_done pulses in any cycle.
- Stall outputs are combinational; every other output is registered.

Optional Feature:
ARB_FAIR_EN:
- Defined: a last_grant flop records the last requester served. When if_req and d_req are both pending in IDLE, the requester not served last wins; with a single requester, it wins. last_grant resets to IF, so data wins the first tie.
- Undefined: fixed data priority; fetch may starve while d_req is continuously asserted.

Test Plan:
- Single fetch: if_req=1, if_addr=0x00400000, mem_ready 1 cycle after mem_req with mem_rdata=0x8C080004 -> mem_addr=0x00400000, mem_be=F, mem_we=0; if_done pulse 1 cycle; if_rdata=0x8C080004; if_stall low same cycle.
- Store with 3-cycle memory wait: d_req, d_we=1, d_addr=0x10010000, d_wdata=0x12345678, d_be=4'b0011 -> mem_* stable for 3 cycles; d_done pulses once; d_rdata unchanged.
- Contention, both requests in the same cycle:
  - Without ARB_FAIR_EN: data served first, then fetch.
  - With ARB_FAIR_EN and both held: grants alternate D, IF, D, IF.
- Flush: if_flush during IF_BUSY, then mem_ready -> no if_done; if_rdata retains its prior value; state IDLE; the next fetch proceeds normally.
- Timeout: TIMEOUT_CYCLES=4, mem_ready never asserted on a load -> mem_req drops after 4 busy cycles; d_done and bus_err pulse together; d_rdata=0xDEADBEEF.
- Async reset mid-D_BUSY: rst low between edges -> mem_req, d_done and bus_err are 0 immediately; after release, IDLE accepts a new request.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the fetch/data requesters, the arbiter and the shared memory.
// The master side drives requests and memory responses; the slave side is the arbiter.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        if_stall;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        d_stall;

  logic        bus_err;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output if_req, if_addr, if_flush,
    input  if_rdata, if_done, if_stall,
    output d_req, d_we, d_addr, d_wdata, d_be,
    input  d_rdata, d_done, d_stall,
    input  bus_err,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_rdata, mem_ready
  );

  modport slave (
    input  if_req, if_addr, if_flush,
    output if_rdata, if_done, if_stall,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    output d_rdata, d_done, d_stall,
    output bus_err,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_rdata, mem_ready
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and load/store; done pulses the cycle after mem_ready or timeout.
// Define ARB_FAIR_EN to alternate grants on ties via last_grant; otherwise data always wins.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave io_bus
);
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    D_BUSY  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_cnt;
  logic        r_drop;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_be;
  logic [31:0] r_if_rdata;
  logic [31:0] r_d_rdata;
  logic        r_if_done;
  logic        r_d_done;
  logic        r_bus_err;

  logic        w_grant_d;
  logic        w_grant_if;
  logic        w_busy;
  logic        w_ready;
  logic        w_expire;
  logic        w_end;
  logic        w_drop_now;

`ifdef ARB_FAIR_EN
  logic        r_last_grant;   // 0 = fetch served last, 1 = data served last
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_grant_d   = 1'b0;
    w_grant_if  = 1'b0;
    w_state_nxt = r_state;
    w_busy      = (r_state != IDLE);
    w_ready     = w_busy & io_bus.mem_ready;
    // mem_ready on the limit cycle wins over the timeout
    w_expire    = w_busy & ~io_bus.mem_ready & (r_cnt == CNT_LAST);
    w_end       = w_ready | w_expire;
    w_drop_now  = (r_state == IF_BUSY) & (r_drop | io_bus.if_flush);
    case (r_state)
      IDLE: begin
`ifdef ARB_FAIR_EN
        if (io_bus.d_req & io_bus.if_req) begin
          w_grant_d  = ~r_last_grant;
          w_grant_if = r_last_grant;
        end else begin
          w_grant_d  = io_bus.d_req;
          w_grant_if = io_bus.if_req;
        end
`else
        w_grant_d  = io_bus.d_req;
        w_grant_if = io_bus.if_req & ~io_bus.d_req;
`endif
        if (w_grant_d) begin
          w_state_nxt = D_BUSY;
        end else if (w_grant_if) begin
          w_state_nxt = IF_BUSY;
        end
      end
      IF_BUSY, D_BUSY: begin
        if (w_end) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt       <= 16'd0;
      r_drop      <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_mem_be    <= 4'd0;
      r_if_rdata  <= 32'd0;
      r_d_rdata   <= 32'd0;
      r_if_done   <= 1'b0;
      r_d_done    <= 1'b0;
      r_bus_err   <= 1'b0;
    end else begin
      r_if_done <= 1'b0;
      r_d_done  <= 1'b0;
      r_bus_err <= 1'b0;
      if (r_state == IDLE) begin
        r_cnt  <= 16'd0;
        r_drop <= 1'b0;
        if (w_grant_d) begin
          r_mem_req   <= 1'b1;
          r_mem_we    <= io_bus.d_we;
          r_mem_addr  <= io_bus.d_addr;
          r_mem_wdata <= io_bus.d_wdata;
          r_mem_be    <= io_bus.d_be;
        end else if (w_grant_if) begin
          r_mem_req   <= 1'b1;
          r_mem_we    <= 1'b0;
          r_mem_addr  <= io_bus.if_addr;
          r_mem_wdata <= 32'd0;
          r_mem_be    <= 4'hF;
        end
      end else if (w_end) begin
        r_mem_req <= 1'b0;
        r_mem_we  <= 1'b0;
        r_drop    <= 1'b0;
        r_bus_err <= w_expire;
        if (r_state == D_BUSY) begin
          r_d_done <= 1'b1;
          if (!r_mem_we) begin
            r_d_rdata <= w_expire ? ERR_RDATA : io_bus.mem_rdata;
          end
        end else if (!w_drop_now) begin
          r_if_done  <= 1'b1;
          r_if_rdata <= w_expire ? ERR_RDATA : io_bus.mem_rdata;
        end
      end else begin
        r_cnt <= r_cnt + 16'd1;
        if ((r_state == IF_BUSY) && io_bus.if_flush) begin
          r_drop <= 1'b1;
        end
      end
    end
  end

`ifdef ARB_FAIR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_grant <= 1'b0;
    end else if (w_grant_d) begin
      r_last_grant <= 1'b1;
    end else if (w_grant_if) begin
      r_last_grant <= 1'b0;
    end
  end
`endif

  assign io_bus.mem_req   = r_mem_req;
  assign io_bus.mem_we    = r_mem_we;
  assign io_bus.mem_addr  = r_mem_addr;
  assign io_bus.mem_wdata = r_mem_wdata;
  assign io_bus.mem_be    = r_mem_be;
  assign io_bus.if_rdata  = r_if_rdata;
  assign io_bus.if_done   = r_if_done;
  assign io_bus.d_rdata   = r_d_rdata;
  assign io_bus.d_done    = r_d_done;
  assign io_bus.bus_err   = r_bus_err;
  assign io_bus.if_stall  = io_bus.if_req & ~r_if_done;
  assign io_bus.d_stall   = io_bus.d_req & ~r_d_done;

endmodule
